// File: rtl/timer_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | timer_sequencer_pkg                                                  |
// | Shared register map, TCR/TSR bit positions, state encodings and      |
// | register-value helpers for the timer sequencer.                      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package timer_sequencer_pkg;

   // Timer register addresses
   localparam logic [7:0] ADDR_TDR = 8'h00;
   localparam logic [7:0] ADDR_TCR = 8'h01;
   localparam logic [7:0] ADDR_TSR = 8'h02;

   // TCR bit positions; cks occupies [1:0]
   localparam int TCR_LOAD_BIT = 7;
   localparam int TCR_UPDN_BIT = 5;
   localparam int TCR_EN_BIT   = 4;

   // TSR bit positions (write-1-to-clear)
   localparam int TSR_OVF_BIT = 0;
   localparam int TSR_UDF_BIT = 1;

   // Sequencer FSM states
   typedef enum logic [3:0] {
      ST_IDLE    = 4'd0,
      ST_WR_TDR  = 4'd1,
      ST_WR_LOAD = 4'd2,
      ST_WR_RUN  = 4'd3,
      ST_RD_TSR  = 4'd4,
      ST_GAP     = 4'd5,
      ST_WR_CLR  = 4'd6,
      ST_WR_STOP = 4'd7,
      ST_FINISH  = 4'd8
   } tseq_state_e;

   // Bus transfer phases
   typedef enum logic [1:0] {
      XF_IDLE   = 2'd0,
      XF_SETUP  = 2'd1,
      XF_ACCESS = 2'd2
   } xfer_phase_e;

   // Assemble a TCR value; unused bits stay zero
   function automatic logic [7:0] tcr_value(input logic load, input logic up,
                                            input logic en, input logic [1:0] cks);
      logic [7:0] v;
      v               = '0;
      v[TCR_LOAD_BIT] = load;
      v[TCR_UPDN_BIT] = up;
      v[TCR_EN_BIT]   = en;
      v[1:0]          = cks;
      return v;
   endfunction

   // TSR bit watched for the given count direction
   function automatic logic [7:0] tsr_mask(input logic up);
      logic [7:0] v;
      v = '0;
      if (up) v[TSR_OVF_BIT] = 1'b1;
      else    v[TSR_UDF_BIT] = 1'b1;
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/timer_sequencer_apb_xfer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tseq_apb_xfer                                                        |
// | Runs one APB-style transfer (setup, access until ready) with an      |
// | access-phase timeout; reports ack/rdata/error as one-cycle results.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tseq_apb_xfer
   import timer_sequencer_pkg::*;
#(
   parameter int XFER_TIMEOUT = 16
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       req_i,
   input  logic       write_i,
   input  logic [7:0] addr_i,
   input  logic [7:0] wdata_i,
   output logic       ack_o,
   output logic [7:0] rdata_o,
   output logic       error_o,
   output logic       m_sel_o,
   output logic       m_enable_o,
   output logic       m_write_o,
   output logic [7:0] m_address_o,
   output logic [7:0] m_wdata_o,
   input  logic [7:0] m_rdata_i,
   input  logic       m_ready_i,
   input  logic       m_slverr_i
);

   localparam int TW = $clog2(XFER_TIMEOUT) + 1;

   xfer_phase_e   phase_q, phase_d;
   logic          sel_q, sel_d, en_q, en_d, wr_q, wr_d;
   logic [7:0]    addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic          ack_q, ack_d, error_q, error_d;
   logic [TW-1:0] tmo_q, tmo_d;

   // Next-state logic: bus pins only change at phase boundaries, so they stay stable during access
   always_comb begin
      phase_d = phase_q;
      sel_d   = sel_q;
      en_d    = en_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      error_d = error_q;
      tmo_d   = tmo_q;
      ack_d   = 1'b0;
      case (phase_q)
         XF_IDLE: begin
            if (req_i) begin
               phase_d = XF_SETUP;
               sel_d   = 1'b1;
               en_d    = 1'b0;
               wr_d    = write_i;
               addr_d  = addr_i;
               wdata_d = wdata_i;
            end
         end
         XF_SETUP: begin
            phase_d = XF_ACCESS;
            en_d    = 1'b1;
            tmo_d   = '0;
         end
         XF_ACCESS: begin
            if (m_ready_i) begin
               phase_d = XF_IDLE;
               sel_d   = 1'b0;
               en_d    = 1'b0;
               ack_d   = 1'b1;
               rdata_d = m_rdata_i;
               error_d = m_slverr_i;
            end else if (tmo_q == TW'(XFER_TIMEOUT - 1)) begin
               // Last allowed access cycle without ready: give up with an error
               phase_d = XF_IDLE;
               sel_d   = 1'b0;
               en_d    = 1'b0;
               ack_d   = 1'b1;
               error_d = 1'b1;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         default: begin
            phase_d = XF_IDLE;
            sel_d   = 1'b0;
            en_d    = 1'b0;
         end
      endcase
   end

   // Transfer state registers; reset drops sel/enable immediately
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         phase_q <= XF_IDLE;
         sel_q   <= 1'b0;
         en_q    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         ack_q   <= 1'b0;
         error_q <= 1'b0;
         tmo_q   <= '0;
      end else begin
         phase_q <= phase_d;
         sel_q   <= sel_d;
         en_q    <= en_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ack_q   <= ack_d;
         error_q <= error_d;
         tmo_q   <= tmo_d;
      end
   end

   assign ack_o       = ack_q;
   assign rdata_o     = rdata_q;
   assign error_o     = error_q;
   assign m_sel_o     = sel_q;
   assign m_enable_o  = en_q;
   assign m_write_o   = wr_q;
   assign m_address_o = addr_q;
   assign m_wdata_o   = wdata_q;

endmodule
`default_nettype wire

// File: rtl/timer_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | timer_sequencer                                                      |
// | Programs a timer over an APB-style master, polls its status flag,    |
// | clears and counts events, and stops on count, request or error.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module timer_sequencer
   import timer_sequencer_pkg::*;
#(
   parameter int POLL_GAP     = 4,
   parameter int XFER_TIMEOUT = 16
) (
   input  logic       tseq_clk,
   input  logic       tseq_reset_n,
   input  logic       start,
   input  logic       stop,
   input  logic [7:0] cfg_tdr,
   input  logic [1:0] cfg_cks,
   input  logic       cfg_up_down,
   input  logic [7:0] cfg_periods,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [7:0] evt_count,
   output logic       m_sel,
   output logic       m_enable,
   output logic       m_write,
   output logic [7:0] m_address,
   output logic [7:0] m_wdata,
   input  logic [7:0] m_rdata,
   input  logic       m_ready,
   input  logic       m_slverr
);

   tseq_state_e state_q;
   logic [7:0]  tdr_q, periods_q, evt_q, gap_q;
   logic [1:0]  cks_q;
   logic        up_q, stop_pend_q, busy_q, done_q, err_q, req_q;

   logic        x_write, x_ack, x_error;
   logic [7:0]  x_addr, x_wdata, x_rdata;
   logic        stop_now, flag_hit, period_hit;
   logic [7:0]  evt_inc;

   assign stop_now   = stop_pend_q | stop;
   assign flag_hit   = |(x_rdata & tsr_mask(up_q));
   assign evt_inc    = (evt_q == 8'hFF) ? evt_q : evt_q + 8'd1;
   assign period_hit = (periods_q != 8'd0) && (evt_inc == periods_q);

   // Transfer contents are a pure function of the state that requests them
   always_comb begin
      x_write = 1'b1;
      x_addr  = ADDR_TCR;
      x_wdata = '0;
      case (state_q)
         ST_WR_TDR:  begin x_addr = ADDR_TDR; x_wdata = tdr_q; end
         ST_WR_LOAD: x_wdata = tcr_value(1'b1, up_q, 1'b0, cks_q);
         ST_WR_RUN:  x_wdata = tcr_value(1'b0, up_q, 1'b1, cks_q);
         ST_RD_TSR:  begin x_write = 1'b0; x_addr = ADDR_TSR; end
         ST_WR_CLR:  begin x_addr = ADDR_TSR; x_wdata = tsr_mask(up_q); end
         ST_WR_STOP: x_wdata = tcr_value(1'b0, up_q, 1'b0, cks_q);
         default:    begin x_write = 1'b0; x_addr = '0; end
      endcase
   end

   // Sequencer FSM: issues one request per transfer state and acts on its ack
   always_ff @(posedge tseq_clk or negedge tseq_reset_n) begin
      if (!tseq_reset_n) begin
         state_q     <= ST_IDLE;
         tdr_q       <= '0;
         cks_q       <= '0;
         up_q        <= 1'b0;
         periods_q   <= '0;
         evt_q       <= '0;
         gap_q       <= '0;
         stop_pend_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         req_q       <= 1'b0;
      end else begin
         req_q  <= 1'b0;
         done_q <= 1'b0;
         if (stop && (state_q != ST_IDLE) && (state_q != ST_FINISH)) stop_pend_q <= 1'b1;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  tdr_q       <= cfg_tdr;
                  cks_q       <= cfg_cks;
                  up_q        <= cfg_up_down;
                  periods_q   <= cfg_periods;
                  busy_q      <= 1'b1;
                  err_q       <= 1'b0;
                  evt_q       <= '0;
                  stop_pend_q <= stop;
                  state_q     <= ST_WR_TDR;
                  req_q       <= 1'b1;
               end
            end
            ST_WR_TDR, ST_WR_LOAD, ST_WR_RUN, ST_RD_TSR, ST_WR_CLR, ST_WR_STOP: begin
               if (x_ack) begin
                  if (x_error) err_q <= 1'b1;
                  if (state_q == ST_WR_CLR && !x_error) evt_q <= evt_inc;
                  if (state_q == ST_WR_STOP) begin
                     state_q <= ST_FINISH;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                  end else if (x_error ||
                               (stop_now && state_q inside {ST_WR_RUN, ST_RD_TSR, ST_WR_CLR})) begin
                     // The programming burst (TDR, LOAD, RUN) always completes before a stop
                     state_q <= ST_WR_STOP;
                     req_q   <= 1'b1;
                  end else begin
                     case (state_q)
                        ST_WR_TDR:  begin state_q <= ST_WR_LOAD; req_q <= 1'b1; end
                        ST_WR_LOAD: begin state_q <= ST_WR_RUN;  req_q <= 1'b1; end
                        ST_WR_RUN:  begin state_q <= ST_RD_TSR;  req_q <= 1'b1; end
                        ST_RD_TSR: begin
                           if (flag_hit) begin
                              state_q <= ST_WR_CLR;
                              req_q   <= 1'b1;
                           end else begin
                              state_q <= ST_GAP;
                              gap_q   <= '0;
                           end
                        end
                        default: begin
                           if (period_hit) begin
                              state_q <= ST_WR_STOP;
                              req_q   <= 1'b1;
                           end else begin
                              state_q <= ST_GAP;
                              gap_q   <= '0;
                           end
                        end
                     endcase
                  end
               end
            end
            ST_GAP: begin
               if (stop_now) begin
                  state_q <= ST_WR_STOP;
                  req_q   <= 1'b1;
               end else if (gap_q == 8'(POLL_GAP - 1)) begin
                  state_q <= ST_RD_TSR;
                  req_q   <= 1'b1;
               end else begin
                  gap_q <= gap_q + 8'd1;
               end
            end
            ST_FINISH: begin
               stop_pend_q <= 1'b0;
               state_q     <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   tseq_apb_xfer #(
      .XFER_TIMEOUT (XFER_TIMEOUT)
   ) u_xfer (
      .clk_i       (tseq_clk),
      .rst_ni      (tseq_reset_n),
      .req_i       (req_q),
      .write_i     (x_write),
      .addr_i      (x_addr),
      .wdata_i     (x_wdata),
      .ack_o       (x_ack),
      .rdata_o     (x_rdata),
      .error_o     (x_error),
      .m_sel_o     (m_sel),
      .m_enable_o  (m_enable),
      .m_write_o   (m_write),
      .m_address_o (m_address),
      .m_wdata_o   (m_wdata),
      .m_rdata_i   (m_rdata),
      .m_ready_i   (m_ready),
      .m_slverr_i  (m_slverr)
   );

   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign evt_count = evt_q;

endmodule
`default_nettype wire
